// File: rtl/pipelined_carry_adder.sv
// -----------------------------------------------------------------------------
// pipelined_carry_adder
//
// Streaming pipelined ripple-carry adder/subtractor. The operand width is cut
// into SLICE-bit slices. Each slice is resolved in its own register stage, and
// each stage hands its carry to the next one. Operands that are not yet
// consumed travel down the pipe next to the partial sum, so that every stage
// sees the operands of its own beat. Latency is STAGES = WIDTH/SLICE cycles
// and throughput is one beat per cycle. A single global stall freezes every
// stage while the output is held and not taken.
//
// Optional feature macro: OVERFLOW_FLAGS_EN
//   defined   -> out_ovf (signed overflow) and out_zero (sum == 0) are
//                registered with the result.
//   undefined -> out_ovf and out_zero are tied to 0 and no flag logic exists.
//
// Parameters
//   WIDTH  operand/sum width; must be a multiple of SLICE
//   SLICE  bits resolved per pipeline stage
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand beat valid
//   in_ready   beat accepted this cycle when in_valid is also high
//   in_a/in_b  operands
//   in_cin     carry-in; used in add mode only
//   in_sub     1: A - B, 0: A + B + cin
//   out_valid  result valid
//   out_ready  downstream takes the result
//   out_sum    result, modulo 2^WIDTH
//   out_cout   carry out of the MSB; in subtract mode 1 means no borrow
//   out_ovf    signed overflow (flags build only, else 0)
//   out_zero   out_sum == 0 (flags build only, else 0)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module pipelined_carry_adder #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int STAGES = WIDTH / SLICE;
  localparam int LAST   = STAGES - 1;

  if (WIDTH % SLICE != 0) begin : g_width_check
    $error("pipelined_carry_adder: WIDTH (%0d) must be a multiple of SLICE (%0d)",
           WIDTH, SLICE);
  end

  // Per-stage registers. Stage k holds the sum bits resolved so far, the
  // carry out of slice k, and the operands its successors still need.
  logic             valid_q [STAGES];
  logic             carry_q [STAGES];
  logic [WIDTH-1:0] a_q     [STAGES];
  logic [WIDTH-1:0] b_q     [STAGES];
  logic [WIDTH-1:0] sum_q   [STAGES];

  // What each stage sees at its input this cycle.
  logic             v_in      [STAGES];
  logic             c_in      [STAGES];
  logic [WIDTH-1:0] a_in      [STAGES];
  logic [WIDTH-1:0] b_in      [STAGES];
  logic [WIDTH-1:0] s_in      [STAGES];
  logic [SLICE:0]   slice_sum [STAGES];
  logic [WIDTH-1:0] s_next    [STAGES];

  // Global stall: the whole pipe moves only when the output slot is free or
  // is being emptied this cycle.
  logic advance;
  assign advance  = !valid_q[LAST] || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      // Subtraction is A + ~B + 1. The forced carry-in is the +1, so in_cin
      // plays no part in subtract mode.
      assign v_in[k] = in_valid;
      assign a_in[k] = in_a;
      assign b_in[k] = in_sub ? ~in_b : in_b;
      assign c_in[k] = in_sub ? 1'b1 : in_cin;
      assign s_in[k] = '0;
    end else begin : g_next
      assign v_in[k] = valid_q[k-1];
      assign a_in[k] = a_q[k-1];
      assign b_in[k] = b_q[k-1];
      assign c_in[k] = carry_q[k-1];
      assign s_in[k] = sum_q[k-1];
    end

    assign slice_sum[k] = {1'b0, a_in[k][k*SLICE +: SLICE]}
                        + {1'b0, b_in[k][k*SLICE +: SLICE]}
                        + {{SLICE{1'b0}}, c_in[k]};
  end

  // Merge the newly resolved slice into the sum forwarded from upstream.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      // NOTE: the whole word is assigned before the slice overwrite, so every
      // bit has a value on every pass and no latch can be inferred.
      s_next[k]                    = s_in[k];
      s_next[k][k*SLICE +: SLICE]  = slice_sum[k][SLICE-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath registers are reset together with the valid bits
      // because out_sum/out_cout must read 0 out of reset, and clearing the
      // rest costs nothing in correctness.
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        carry_q[k] <= 1'b0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
        sum_q[k]   <= '0;
      end
    end else if (advance) begin
      // NOTE: non-blocking assignments let every stage take its
      // predecessor's old value on the same edge, which gives a true shift.
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= v_in[k];
        carry_q[k] <= slice_sum[k][SLICE];
        a_q[k]     <= a_in[k];
        b_q[k]     <= b_in[k];
        sum_q[k]   <= s_next[k];
      end
    end
  end

  assign out_valid = valid_q[LAST];
  assign out_sum   = sum_q[LAST];
  assign out_cout  = carry_q[LAST];

`ifdef OVERFLOW_FLAGS_EN
  // The carry into the MSB is recovered from the MSB's own sum bit:
  // sum = a ^ b ^ cin, so cin = a ^ b ^ sum. Signed overflow is that carry
  // XOR the carry out of the MSB.
  logic msb_carry_in;
  logic ovf_q;
  logic zero_q;

  assign msb_carry_in = a_in[LAST][WIDTH-1] ^ b_in[LAST][WIDTH-1] ^ s_next[LAST][WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (advance) begin
      ovf_q  <= msb_carry_in ^ slice_sum[LAST][SLICE];
      zero_q <= (s_next[LAST] == '0);
    end
  end

  assign out_ovf  = ovf_q;
  assign out_zero = zero_q;
`else
  assign out_ovf  = 1'b0;
  assign out_zero = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// -----------------------------------------------------------------------------
// tb_pipelined_carry_adder
//
// Bench for pipelined_carry_adder. It runs a 16/4 instance through directed
// vectors, a stall sequence and a reset applied while beats are in flight. It
// also streams random back-to-back beats through a 32/8 instance. A
// negedge-clocked compare process checks every output beat against an
// arithmetic model that is kept in per-instance queues.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_pipelined_carry_adder;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    int          acc;     // cycle count when the beat was accepted
    int          stalls;  // stall count when the beat was accepted
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 16-bit / 4-bit-slice instance
  logic        in_valid, in_ready, in_cin, in_sub;
  logic [15:0] in_a, in_b;
  logic        out_valid, out_ready, out_cout, out_ovf, out_zero;
  logic [15:0] out_sum;

  // 32-bit / 8-bit-slice instance
  logic        x_in_valid, x_in_ready, x_in_cin, x_in_sub;
  logic [31:0] x_in_a, x_in_b;
  logic        x_out_valid, x_out_ready, x_out_cout, x_out_ovf, x_out_zero;
  logic [31:0] x_out_sum;

  pipelined_carry_adder #(.WIDTH(16), .SLICE(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero)
  );

  pipelined_carry_adder #(.WIDTH(32), .SLICE(8)) dut32 (
    .clk(clk), .rst(rst),
    .in_valid(x_in_valid), .in_ready(x_in_ready),
    .in_a(x_in_a), .in_b(x_in_b), .in_cin(x_in_cin), .in_sub(x_in_sub),
    .out_valid(x_out_valid), .out_ready(x_out_ready),
    .out_sum(x_out_sum), .out_cout(x_out_cout), .out_ovf(x_out_ovf), .out_zero(x_out_zero)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int stall16 = 0;
  int stall32 = 0;
  exp_t q16[$];
  exp_t q32[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference: unsigned sum/carry and signed overflow taken
  // straight from integer arithmetic on w-bit operands.
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub);
    exp_t e;
    longint unsigned mask, full;
    longint sa, sb, sr, lim;
    mask = (64'd1 << w) - 64'd1;
    lim  = longint'(64'd1 << (w - 1));
    sa = longint'(a);
    sb = longint'(b);
    if (sa >= lim) sa = sa - 2 * lim;
    if (sb >= lim) sb = sb - 2 * lim;
    if (sub) begin
      full   = (64'(a) - 64'(b)) & mask;
      e.cout = (a >= b);
      sr     = sa - sb;
    end else begin
      full   = 64'(a) + 64'(b) + 64'(cin);
      e.cout = full[w];
      sr     = sa + sb + longint'(cin);
    end
    e.sum    = 32'(full & mask);
    e.ovf    = (sr >= lim) || (sr < -lim);
    e.zero   = (e.sum == 32'd0);
    e.acc    = 0;
    e.stalls = 0;
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Compare process: it runs on the falling edge, when the inputs and outputs
  // are stable for the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q16.delete();
      q32.delete();
    end else begin
      // ---- 16-bit instance ----
      check("in_ready_rule16", in_ready, !out_valid || out_ready);
      if (out_valid) begin
        if (q16.size() == 0) begin
          check("unexpected_out16", out_valid, 1'b0);
        end else begin
          e = q16[0];
          check("sum16", out_sum, e.sum[15:0]);
          check("cout16", out_cout, e.cout);
`ifdef OVERFLOW_FLAGS_EN
          check("ovf16", out_ovf, e.ovf);
          check("zero16", out_zero, e.zero);
`else
          check("ovf16_tied", out_ovf, 1'b0);
          check("zero16_tied", out_zero, 1'b0);
`endif
          if (out_ready) begin
            if (e.stalls == stall16) check("latency16", cyc - e.acc, 4);
            void'(q16.pop_front());
          end
        end
        if (!out_ready) stall16++;
      end
      if (in_valid && in_ready) begin
        e = model(16, {16'h0, in_a}, {16'h0, in_b}, in_cin, in_sub);
        e.acc = cyc;
        e.stalls = stall16;
        q16.push_back(e);
      end

      // ---- 32-bit instance ----
      check("in_ready_rule32", x_in_ready, !x_out_valid || x_out_ready);
      if (x_out_valid) begin
        if (q32.size() == 0) begin
          check("unexpected_out32", x_out_valid, 1'b0);
        end else begin
          e = q32[0];
          check("sum32", x_out_sum, e.sum);
          check("cout32", x_out_cout, e.cout);
`ifdef OVERFLOW_FLAGS_EN
          check("ovf32", x_out_ovf, e.ovf);
          check("zero32", x_out_zero, e.zero);
`else
          check("ovf32_tied", x_out_ovf, 1'b0);
          check("zero32_tied", x_out_zero, 1'b0);
`endif
          if (x_out_ready) begin
            if (e.stalls == stall32) check("latency32", cyc - e.acc, 4);
            void'(q32.pop_front());
          end
        end
        if (!x_out_ready) stall32++;
      end
      if (x_in_valid && x_in_ready) begin
        e = model(32, x_in_a, x_in_b, x_in_cin, x_in_sub);
        e.acc = cyc;
        e.stalls = stall32;
        q32.push_back(e);
      end
    end
  end

  // One beat into an idle 16-bit pipe with out_ready high. The expected values
  // are literals worked out by hand.
  task automatic directed(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub,
                          input logic [15:0] esum, input logic ecout,
                          input logic eovf, input logic ezero);
    int n;
    in_a = a; in_b = b; in_cin = cin; in_sub = sub;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 12) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_latency"}, n, 4);
    check({name, "_valid"}, out_valid, 1'b1);
    check({name, "_sum"}, out_sum, esum);
    check({name, "_cout"}, out_cout, ecout);
`ifdef OVERFLOW_FLAGS_EN
    check({name, "_ovf"}, out_ovf, eovf);
    check({name, "_zero"}, out_zero, ezero);
`else
    check({name, "_ovf_tied"}, out_ovf, 1'b0);
    check({name, "_zero_tied"}, out_zero, 1'b0);
    if (eovf && ezero) $display("note: both flags expected for %s", name);
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout reached at t=%0t", $time);
    $fatal(1);
  end

  initial begin
    logic [15:0] sa [6];
    logic [15:0] sb [6];
    logic        ssub [6];
    int  sent;
    logic acc;

    rst = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b1;
    x_in_valid = 1'b0; x_in_a = '0; x_in_b = '0; x_in_cin = 1'b0; x_in_sub = 1'b0;
    x_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_sum", out_sum, 16'h0000);
    check("rst_out_cout", out_cout, 1'b0);
    check("rst_out_ovf", out_ovf, 1'b0);
    check("rst_out_zero", out_zero, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid32", x_out_valid, 1'b0);
    check("rst_out_sum32", x_out_sum, 32'h0);

    // Directed vectors: wrap-around, borrow/no-borrow, carry-in, cin ignored
    // in subtract mode, signed overflow and zero.
    directed("add_wrap",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    directed("sub_borrow", 16'h1234, 16'h1235, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    directed("sub_nobrw",  16'h1235, 16'h1234, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0);
    directed("add_cin",    16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
    directed("sub_cinign", 16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);
    directed("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    directed("sub_zero",   16'h8000, 16'h8000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);

    // Stall: six beats with out_ready dropped after the first result.
    sa   = '{16'h0001, 16'h1000, 16'hABCD, 16'h8000, 16'h00FF, 16'hFFFF};
    sb   = '{16'h0002, 16'h0FFF, 16'h1111, 16'h0001, 16'h0F01, 16'hFFFF};
    ssub = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    sent = 0;
    for (int t = 0; t < 40 && !(sent == 6 && q16.size() == 0); t++) begin
      in_valid = (sent < 6);
      if (sent < 6) begin
        in_a = sa[sent]; in_b = sb[sent]; in_sub = ssub[sent]; in_cin = 1'b0;
      end
      out_ready = (t <= 4) || (t >= 10);
      @(negedge clk);
      if (t >= 5 && t <= 9) begin
        check("stall_in_ready", in_ready, 1'b0);
        check("stall_out_valid", out_valid, 1'b1);
      end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("stall_all_sent", sent, 6);
    check("stall_drained", q16.size(), 0);

    // Reset with three beats in flight. None of them may come out.
    for (int i = 0; i < 3; i++) begin
      in_a = 16'(16'h1111 * (i + 1)); in_b = 16'h0101; in_sub = 1'b0; in_cin = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 6; i++) begin
      check("midrst_no_out", out_valid, 1'b0);
      @(posedge clk); #1;
    end

    // 32/8 instance: random back-to-back operands and modes.
    for (int i = 0; i < 60; i++) begin
      x_in_a   = (i % 10 == 0) ? 32'hFFFF_FFFF : 32'($urandom);
      x_in_b   = (i % 10 == 0) ? 32'h0000_0001 : 32'($urandom);
      x_in_sub = 1'($urandom_range(0, 1));
      x_in_cin = 1'($urandom_range(0, 1));
      x_in_valid = 1'b1;
      @(posedge clk); #1;
    end
    x_in_valid = 1'b0;
    for (int i = 0; i < 20 && (q32.size() != 0 || q16.size() != 0); i++) begin
      @(posedge clk); #1;
    end
    check("final_drain16", q16.size(), 0);
    check("final_drain32", q32.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
